// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pkg
//  Description : Shared constants and helpers for the memory/writeback stage:
//                RV32I load/store funct3 codes, stage state encoding, access
//                size decode, store byte-enable generation and alignment test.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Unknown funct3 codes fall through to a full-word access.
    function automatic access_size_e access_size(input logic [2:0] f3);
        access_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            F3_W:        sz = SZ_WORD;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (access_size(f3))
            SZ_BYTE: s = 4'b0001 << a;
            SZ_HALF: s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (access_size(f3))
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = |a;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Combinational load formatter. Selects the addressed byte or
//                half-word lane of the read word and sign/zero extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension according to the access type.
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   result_o = {{(XLEN-16){1'b0}}, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access and writeback stage. ALU results are written
//                back the cycle after acceptance; loads/stores run a req/ack
//                transaction to the data RAM while execute is stalled.
//                Build option: MISALIGN_TRAP_EN adds misalign_o and suppresses
//                misaligned half/word accesses instead of truncating them.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [XLEN-1:0]   ex_alu_result_i,
    input  logic [XLEN-1:0]   ex_rs2_data_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_reg_we_i,
    input  logic              ex_mem_re_i,
    input  logic              ex_mem_we_i,
    input  logic [2:0]        ex_funct3_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              reg_write_en_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    logic [1:0]        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   rwdata_q, rwdata_d;
    logic              wen_q, wen_d;

    logic              accept;
    logic              is_mem;
    logic              trap;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;

    assign ex_ready_o = rst & (state_q == S_IDLE);
    assign accept     = ex_valid_i & ex_ready_o;
    assign is_mem     = ex_mem_re_i | ex_mem_we_i;

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(ex_funct3_i, ex_alu_result_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Replicate the store operand across every lane it could land in.
    always_comb begin
        case (access_size(ex_funct3_i))
            SZ_BYTE: store_data = {(XLEN/8){ex_rs2_data_i[7:0]}};
            SZ_HALF: store_data = {(XLEN/16){ex_rs2_data_i[15:0]}};
            default: store_data = ex_rs2_data_i;
        endcase
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (off_q),
        .rdata_i   (mem_rdata_i),
        .result_o  (load_data)
    );

    // Next-state and datapath capture; write strobe defaults to a 1-cycle pulse.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        we_d     = we_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        waddr_d  = waddr_q;
        rwdata_d = rwdata_q;
        wen_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem && !trap) begin
                        // A set load bit wins over a set store bit.
                        we_d    = ex_mem_we_i & ~ex_mem_re_i;
                        addr_d  = {ex_alu_result_i[XLEN-1:2], 2'b00};
                        wdata_d = store_data;
                        wstrb_d = (ex_mem_we_i & ~ex_mem_re_i)
                                ? store_strobe(ex_funct3_i, ex_alu_result_i[1:0]) : 4'b0000;
                        f3_d    = ex_funct3_i;
                        off_d   = ex_alu_result_i[1:0];
                        rd_d    = ex_rd_i;
                        state_d = S_MEM;
                    end else if (!is_mem) begin
                        waddr_d  = ex_rd_i;
                        rwdata_d = ex_alu_result_i;
                        wen_d    = ex_reg_we_i & (|ex_rd_i);
                    end
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        waddr_d  = rd_q;
                        rwdata_d = load_data;
                        wen_d    = |rd_q;
                        state_d  = S_WB;
                    end
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            rd_q     <= '0;
            waddr_q  <= '0;
            rwdata_q <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            waddr_q  <= waddr_d;
            rwdata_q <= rwdata_d;
            wen_q    <= wen_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    // One-cycle pulse after a suppressed misaligned access is accepted.
    always_ff @(posedge clk) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= accept & is_mem & trap;
    end

    assign misalign_o = mis_q;
`endif

    assign mem_req_o      = (state_q == S_MEM);
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_wstrb_o    = wstrb_q;
    assign reg_waddr_o    = waddr_q;
    assign reg_wdata_o    = rwdata_q;
    assign reg_write_en_o = wen_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage: directed scenarios plus
//                randomized ALU/load/store traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] ex_alu_result_i = '0;
    logic [31:0] ex_rs2_data_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic        ex_reg_we_i = 1'b0;
    logic        ex_mem_re_i = 1'b0;
    logic        ex_mem_we_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_write_en_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_alu_result_i (ex_alu_result_i),
        .ex_rs2_data_i   (ex_rs2_data_i),
        .ex_rd_i         (ex_rd_i),
        .ex_reg_we_i     (ex_reg_we_i),
        .ex_mem_re_i     (ex_mem_re_i),
        .ex_mem_we_i     (ex_mem_we_i),
        .ex_funct3_i     (ex_funct3_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wstrb_o     (mem_wstrb_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .reg_write_en_o  (reg_write_en_o)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int a;
        int v;
        a = int'(addr & 32'd3);
        if (size_bytes(f3) == 1) begin
            v = int'((word >> (8 * a)) & 32'hFF);
            if (f3 == 3'd0 && v > 127) v = v - 256;
            return 32'(v);
        end
        if (size_bytes(f3) == 2) begin
            v = int'((word >> (16 * (a / 2))) & 32'hFFFF);
            if (f3 == 3'd1 && v > 32767) v = v - 65536;
            return 32'(v);
        end
        return word;
    endfunction

    function automatic logic [31:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        a = int'(addr & 32'd3);
        if (size_bytes(f3) == 1) return 32'(1 << a);
        if (size_bytes(f3) == 2) return 32'(3 << (2 * (a / 2)));
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (size_bytes(f3) == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (size_bytes(f3) == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr & 32'd3) % size_bytes(f3)) != 0;
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic alu_op(input logic [4:0] rd, input logic [31:0] res, input logic we);
        check("alu_ready", 32'(ex_ready_o), 32'd1);
        ex_valid_i = 1'b1; ex_alu_result_i = res; ex_rd_i = rd; ex_reg_we_i = we;
        ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0; ex_funct3_i = 3'($urandom_range(0, 7));
        step();
        ex_valid_i = 1'b0;
        check("alu_wen", 32'(reg_write_en_o), 32'(we && rd != 5'd0));
        if (we && rd != 5'd0) begin
            check("alu_waddr", 32'(reg_waddr_o), 32'(rd));
            check("alu_wdata", reg_wdata_o, res);
        end
        check("alu_req", 32'(mem_req_o), 32'd0);
    endtask

    task automatic mem_op(input bit is_load, input bit both, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input logic [4:0] rd, input int waitc);
        bit trap;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = ref_misaligned(f3, addr);
`endif
        check("mem_ready_idle", 32'(ex_ready_o), 32'd1);
        ex_valid_i = 1'b1; ex_alu_result_i = addr; ex_rs2_data_i = rs2; ex_rd_i = rd;
        ex_reg_we_i = 1'b1; ex_mem_re_i = is_load; ex_mem_we_i = !is_load || both;
        ex_funct3_i = f3;
        step();
        ex_valid_i = 1'b0; ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0;
        if (trap) begin
`ifdef MISALIGN_TRAP_EN
            check("trap_pulse", 32'(misalign_o), 32'd1);
            check("trap_req", 32'(mem_req_o), 32'd0);
            check("trap_wen", 32'(reg_write_en_o), 32'd0);
            check("trap_ready", 32'(ex_ready_o), 32'd1);
            step();
            check("trap_pulse_end", 32'(misalign_o), 32'd0);
            check("trap_req2", 32'(mem_req_o), 32'd0);
            check("trap_wen2", 32'(reg_write_en_o), 32'd0);
`endif
        end else begin
            check("req_rise", 32'(mem_req_o), 32'd1);
            check("req_we", 32'(mem_we_o), 32'(!is_load));
            check("req_addr", mem_addr_o, addr & ~32'd3);
            check("stall", 32'(ex_ready_o), 32'd0);
            if (!is_load) begin
                check("st_strb", 32'(mem_wstrb_o), ref_strb(f3, addr));
                check("st_wdata", mem_wdata_o, ref_wdata(f3, rs2));
            end
            for (int i = 0; i < waitc; i++) begin
                step();
                check("req_hold", 32'(mem_req_o), 32'd1);
                check("addr_hold", mem_addr_o, addr & ~32'd3);
                check("stall_hold", 32'(ex_ready_o), 32'd0);
                check("wen_wait", 32'(reg_write_en_o), 32'd0);
            end
            mem_ack_i = 1'b1; mem_rdata_i = rdata;
            step();
            mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            check("req_drop", 32'(mem_req_o), 32'd0);
            if (is_load) begin
                check("ld_wen", 32'(reg_write_en_o), 32'(rd != 5'd0));
                if (rd != 5'd0) begin
                    check("ld_waddr", 32'(reg_waddr_o), 32'(rd));
                    check("ld_wdata", reg_wdata_o, ref_load(f3, addr, rdata));
                end
                check("ld_wb_stall", 32'(ex_ready_o), 32'd0);
                step();
                check("ld_wen_end", 32'(reg_write_en_o), 32'd0);
            end else begin
                check("st_no_wen", 32'(reg_write_en_o), 32'd0);
            end
            check("back_idle", 32'(ex_ready_o), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        step();
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_wen", 32'(reg_write_en_o), 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check("rst_wdata", reg_wdata_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_strb", 32'(mem_wstrb_o), 32'd0);
        check("rst_ready_held", 32'(ex_ready_o), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("rst_ready_release", 32'(ex_ready_o), 32'd1);

        // Back-to-back ALU ops: x5 then x0
        ex_valid_i = 1'b1; ex_alu_result_i = 32'h1234_5678; ex_rd_i = 5'd5; ex_reg_we_i = 1'b1;
        step();
        ex_alu_result_i = 32'hDEAD_BEEF; ex_rd_i = 5'd0;
        check("b2b_wen", 32'(reg_write_en_o), 32'd1);
        check("b2b_waddr", 32'(reg_waddr_o), 32'd5);
        check("b2b_wdata", reg_wdata_o, 32'h1234_5678);
        check("b2b_ready", 32'(ex_ready_o), 32'd1);
        step();
        ex_valid_i = 1'b0;
        check("x0_no_wen", 32'(reg_write_en_o), 32'd0);
        check("x0_ready", 32'(ex_ready_o), 32'd1);
        alu_op(5'd9, 32'hCAFE_0001, 1'b0);

        // Directed memory accesses
        mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd7, 3);
        mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 5'd8, 0);
        mem_op(1'b0, 1'b0, 3'b000, 32'h0000_0201, 32'hAABB_CCDD, 32'h0, 5'd3, 1);
        mem_op(1'b1, 1'b1, 3'b001, 32'h0000_0040, 32'h5555_5555, 32'h0000_8001, 5'd4, 0);
        mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h0BAD_F00D, 5'd6, 1);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0011, 32'h0, 32'h1111_F00F, 5'd0, 0);

        // Reset while waiting for ack; a late ack must not write back
        ex_valid_i = 1'b1; ex_alu_result_i = 32'h300; ex_rd_i = 5'd12; ex_reg_we_i = 1'b1;
        ex_mem_re_i = 1'b1; ex_mem_we_i = 1'b0; ex_funct3_i = 3'b010;
        step();
        ex_valid_i = 1'b0; ex_mem_re_i = 1'b0;
        check("mid_req", 32'(mem_req_o), 32'd1);
        rst = 1'b0;
        step();
        check("mid_rst_req", 32'(mem_req_o), 32'd0);
        rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #1;
        check("mid_rst_ready", 32'(ex_ready_o), 32'd1);
        step();
        mem_ack_i = 1'b0;
        check("late_ack_wen", 32'(reg_write_en_o), 32'd0);
        check("late_ack_req", 32'(mem_req_o), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [2:0] f3;
            logic [4:0] rd;
            kind = int'($urandom_range(0, 2));
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (kind == 0) begin
                alu_op(rd, $urandom, 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                f3 = 3'($urandom_range(0, 7));
                mem_op(1'b1, ($urandom_range(0, 3) == 0), f3, $urandom, $urandom, $urandom,
                       rd, int'($urandom_range(0, 3)));
            end else begin
                f3 = 3'($urandom_range(0, 2));
                mem_op(1'b0, 1'b0, f3, $urandom, $urandom, $urandom, rd,
                       int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage between execute and the register file; the register file is its consumer.
- Accepts one execute result per handshake. Issues load/store requests to the data RAM over a req/ack handshake.
- Aligns and extends load data, then drives the register-file write port (waddr/wdata/write_en).
- Stalls execute while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath and address width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- ex_valid_i  in  1  execute presents an instruction
- ex_ready_o  out  1  stage accepts the instruction this cycle
- ex_alu_result_i  in  XLEN  ALU result / effective address
- ex_rs2_data_i  in  XLEN  store data
- ex_rd_i  in  REG_AW  destination register
- ex_reg_we_i  in  1  instruction writes rd
- ex_mem_re_i  in  1  load
- ex_mem_we_i  in  1  store
- ex_funct3_i  in  3  access size/sign (RV32I encoding)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  request is a write
- mem_addr_o  out  XLEN  word-aligned address (bits[1:0]=0)
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_wstrb_o  out  4  byte enables
- mem_ack_i  in  1  memory completes the request; rdata valid same cycle
- mem_rdata_i  in  XLEN  read word
- reg_waddr_o  out  REG_AW  register-file write address
- reg_wdata_o  out  XLEN  register-file write data
- reg_write_en_o  out  1  register-file write strobe

Behaviour:
- Reset: rst=0 sampled at a clk edge forces IDLE. All outputs go to 0, except ex_ready_o, which goes to 1 after reset releases. A reset mid-access drops mem_req_o the next edge, and any late ack is ignored.
- Handshake: accept occurs when ex_valid_i & ex_ready_o. ex_ready_o=1 only in IDLE.
- States: IDLE, MEM, WB.
- IDLE, accept, non-memory op:
  - Next cycle: reg_waddr_o=rd, reg_wdata_o=alu_result, reg_write_en_o=ex_reg_we_i & (rd!=0), asserted for exactly 1 cycle.
  - Remain in IDLE, so back-to-back ALU ops sustain 1 per cycle.
- IDLE, accept, load or store:
  - Register address, data, strobes, funct3 and rd; go to MEM.
  - mem_req_o rises the next cycle.
- MEM:
  - mem_req_o and all mem_* outputs stay stable until mem_ack_i.
  - On ack for a store: drop req and return to IDLE. No register write.
  - On ack for a load: capture the aligned/extended data and go to WB; req drops.
- WB: reg_write_en_o=1 (0 if rd==0) for one cycle with the load data, then IDLE.
  - Load-use latency from accept = 2 + (cycles waiting for ack).
- If both ex_mem_re_i and ex_mem_we_i are set, the load takes priority.
- reg_write_en_o is never asserted while rd==0.
- Store lanes, with a=addr[1:0]:
  - SB: wstrb=0001<<a, wdata={4{rs2[7:0]}}
  - SH: wstrb=0011<<{a[1],0}, wdata={2{rs2[15:0]}}
  - SW: wstrb=1111, wdata=rs2
- Load select:
  - LB/LBU: byte a
  - LH/LHU: half a[1]
  - LW: whole word
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Without the optional feature, address bits below the access size are ignored: LH at addr 1 reads half 0; LW at addr 3 reads the aligned word.
- Undefined funct3 values for memory ops are treated as word accesses.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- When defined:
  - Adds port misalign_o (out, 1).
  - A misaligned LH/LHU/SH (a[0]=1) or LW/SW (a!=0) raises no memory request and no register write.
  - misalign_o pulses 1 cycle, the cycle after accept; the stage stays in IDLE.
- When undefined: no port; truncating behaviour as above.

Decomposition:
- Package mem_wb_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE/MEM/WB.
- Sub-module lsu_load_align: combinational; funct3 + addr[1:0] + rdata in, extended 32-bit result out.

Test Plan:
- ALU op rd=5, result 0x1234_5678, then an ALU op with rd=0 → next cycle write x5=0x12345678; following cycle reg_write_en_o=0; ex_ready_o stays 1.
- LB addr 0x103, memory returns 0x80FF_0000 after 3 wait cycles → mem_addr_o=0x100, req held 3 cycles; WB writes 0xFFFF_FF80; ex_ready_o low throughout.
- LHU addr 0x102, rdata 0xBEEF_1234 → write 0x0000_BEEF.
- SB rs2=0xAABBCCDD addr 0x201 → wstrb 0010, wdata 0xDDDDDDDD, mem_we_o=1, no register write; IDLE one cycle after ack.
- rst=0 while in MEM before ack → next edge mem_req_o=0, stage in IDLE; ack asserted afterwards causes no register write.
- With MISALIGN_TRAP_EN: LW addr 0x2 → misalign_o 1 cycle, mem_req_o never rises, no register write.
